// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
// The memory map is owned by `memory`; it is kept here so neighbours decode it the same way.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [31:0] PROGMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] PROGMEM_LAST = 32'h000F_FFFF;
    localparam logic [31:0] RAM_BASE     = 32'h8000_0000;
    localparam logic [31:0] RAM_LAST     = 32'h8000_0FFF;
    localparam logic [31:0] IO_BASE      = 32'hFFFF_0000;
    localparam logic [31:0] IO_LAST      = 32'hFFFF_0007;

    function automatic logic in_range(logic [31:0] addr, logic [31:0] lo, logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-requester grant logic: round-robin on contention, or data-first when ROUND_ROBIN=0.
// last_grant starts at DATA so the fetch port wins the first contention after reset.
module rr_pick2
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_f_i,
    input  logic req_d_i,
    output logic gnt_f_o,
    output logic gnt_d_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_f_o = 1'b0;
        gnt_d_o = 1'b0;
        last_d  = last_q;
        if (en_i) begin
            if (req_f_i && req_d_i) begin
                if ((ROUND_ROBIN != 0) && (last_q == PORT_DATA)) gnt_f_o = 1'b1;
                else                                             gnt_d_o = 1'b1;
            end else if (req_f_i) begin
                gnt_f_o = 1'b1;
            end else if (req_d_i) begin
                gnt_d_o = 1'b1;
            end
        end
        if (gnt_f_o) last_d = PORT_FETCH;
        if (gnt_d_o) last_d = PORT_DATA;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= PORT_DATA;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-ported memory between instruction fetch and load/store.
// IDLE/RESP accept a request, ACCESS drives memory for one cycle, RESP returns a one-cycle response.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:2] i_req_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    output logic        i_rsp_fault,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:2] d_req_addr,
    input  logic [31:0] d_req_wdata,
    input  logic [3:0]  d_req_wstrb,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_fault,
    output logic [31:2] mem_address,
    output logic [31:0] mem_in,
    output logic [3:0]  mem_write_enable,
    input  logic [31:0] mem_out,
    input  logic        mem_read_capable,
    input  logic        mem_write_capable
);

    state_e      state_q, state_d;
    logic        port_q, port_d;
    logic [31:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_fault_q, rsp_fault_d;

    logic gnt_f, gnt_d, accept, is_store, fault;

    assign accept = (state_q != ST_ACCESS);

    rr_pick2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (accept),
        .req_f_i (i_req_valid),
        .req_d_i (d_req_valid),
        .gnt_f_o (gnt_f),
        .gnt_d_o (gnt_d)
    );

    // Fetches latch a zero strobe, so they always decode as loads.
    assign is_store = (port_q == PORT_DATA) && (wstrb_q != 4'd0);
    assign fault    = is_store ? !mem_write_capable : !mem_read_capable;

    always_comb begin
        state_d          = state_q;
        port_d           = port_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wstrb_d          = wstrb_q;
        rsp_data_d       = rsp_data_q;
        rsp_fault_d      = rsp_fault_q;
        mem_write_enable = 4'd0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (gnt_f || gnt_d) begin
                    state_d = ST_ACCESS;
                    port_d  = gnt_d ? PORT_DATA : PORT_FETCH;
                    addr_d  = gnt_d ? d_req_addr : i_req_addr;
                    wdata_d = gnt_d ? d_req_wdata : 32'd0;
                    wstrb_d = gnt_d ? d_req_wstrb : 4'd0;
                end
            end
            ST_ACCESS: begin
                if (is_store && !fault) mem_write_enable = wstrb_q;
                rsp_data_d  = (!is_store && !fault) ? mem_out : 32'd0;
                rsp_fault_d = fault;
                state_d     = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            port_q      <= PORT_FETCH;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_in      = wdata_q;
    assign i_req_ready = gnt_f;
    assign d_req_ready = gnt_d;
    assign i_rsp_valid = (state_q == ST_RESP) && (port_q == PORT_FETCH);
    assign d_rsp_valid = (state_q == ST_RESP) && (port_q == PORT_DATA);
    assign i_rsp_data  = rsp_data_q;
    assign d_rsp_data  = rsp_data_q;
    assign i_rsp_fault = i_rsp_valid && rsp_fault_q;
    assign d_rsp_fault = d_rsp_valid && rsp_fault_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural memory (progmem RO, RAM RW, IO WO).
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk, rst_n;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_fault;
    logic [31:2] i_req_addr;
    logic [31:0] i_rsp_data;
    logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_fault;
    logic [31:2] d_req_addr;
    logic [31:0] d_req_wdata, d_rsp_data;
    logic [3:0]  d_req_wstrb;
    logic [31:2] mem_address;
    logic [31:0] mem_in, mem_out;
    logic [3:0]  mem_write_enable;
    logic        mem_read_capable, mem_write_capable;

    // fixed-priority instance, fed by a trivial always-capable memory
    logic        fp_i_valid, fp_d_valid, fp_i_ready, fp_d_ready;
    logic        fp_i_rv, fp_i_rf, fp_d_rv, fp_d_rf;
    logic [31:0] fp_i_rd, fp_d_rd, fp_mem_in;
    logic [31:2] fp_mem_addr;
    logic [3:0]  fp_we;

    mem_bus_arbiter #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_fault(i_rsp_fault),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_fault(d_rsp_fault),
        .mem_address(mem_address), .mem_in(mem_in), .mem_write_enable(mem_write_enable),
        .mem_out(mem_out), .mem_read_capable(mem_read_capable), .mem_write_capable(mem_write_capable)
    );

    mem_bus_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(fp_i_valid), .i_req_ready(fp_i_ready), .i_req_addr(30'd0),
        .i_rsp_valid(fp_i_rv), .i_rsp_data(fp_i_rd), .i_rsp_fault(fp_i_rf),
        .d_req_valid(fp_d_valid), .d_req_ready(fp_d_ready), .d_req_addr(30'd0),
        .d_req_wdata(32'd0), .d_req_wstrb(4'd0),
        .d_rsp_valid(fp_d_rv), .d_rsp_data(fp_d_rd), .d_rsp_fault(fp_d_rf),
        .mem_address(fp_mem_addr), .mem_in(fp_mem_in), .mem_write_enable(fp_we),
        .mem_out(32'h0), .mem_read_capable(1'b1), .mem_write_capable(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] pm  [0:255];
    logic [31:0] ram [0:1023];
    logic [31:0] io  [0:1];
    logic [31:0] mbyte;
    assign mbyte = {mem_address, 2'b00};

    initial begin
        for (int i = 0; i < 256; i++)  pm[i]  = 32'h1000_0000 + i;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        io[0] = 32'h0;
        io[1] = 32'h0;
    end

    always_comb begin
        mem_read_capable  = 1'b0;
        mem_write_capable = 1'b0;
        mem_out           = 32'h0;
        if (in_range(mbyte, PROGMEM_BASE, PROGMEM_LAST)) begin
            mem_read_capable = 1'b1;
            mem_out          = pm[mem_address[9:2]];
        end else if (in_range(mbyte, RAM_BASE, RAM_LAST)) begin
            mem_read_capable  = 1'b1;
            mem_write_capable = 1'b1;
            mem_out           = ram[mem_address[11:2]];
        end else if (in_range(mbyte, IO_BASE, IO_LAST)) begin
            mem_write_capable = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (mem_write_enable != 4'd0) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_write_enable[b]) begin
                    if (in_range(mbyte, RAM_BASE, RAM_LAST))
                        ram[mem_address[11:2]][8*b +: 8] <= mem_in[8*b +: 8];
                    else if (in_range(mbyte, IO_BASE, IO_LAST))
                        io[mem_address[2]][8*b +: 8] <= mem_in[8*b +: 8];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t fq[$];
    exp_t dq[$];
    int   glog[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   we_cnt = 0;
    bit   log_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_write_enable != 4'd0) we_cnt++;
        if (log_en) begin
            if (i_req_ready) glog.push_back(0);
            if (d_req_ready) glog.push_back(1);
        end
        if (i_rsp_valid) begin
            if (fq.size() == 0) check("i_rsp_unexpected", 32'd1, 32'd0);
            else begin
                mon_e = fq.pop_front();
                check("i_rsp_data", i_rsp_data, mon_e.data);
                check("i_rsp_fault", {31'd0, i_rsp_fault}, {31'd0, mon_e.fault});
                check("i_rsp_latency", cyc, mon_e.cyc + 2);
            end
        end
        if (d_rsp_valid) begin
            if (dq.size() == 0) check("d_rsp_unexpected", 32'd1, 32'd0);
            else begin
                mon_e = dq.pop_front();
                check("d_rsp_data", d_rsp_data, mon_e.data);
                check("d_rsp_fault", {31'd0, d_rsp_fault}, {31'd0, mon_e.fault});
                check("d_rsp_latency", cyc, mon_e.cyc + 2);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_rdy(input bit port, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (port ? d_req_ready : i_req_ready) begin
                ok = 1'b1;
                return;
            end
        end
        check(port ? "d_grant_timeout" : "i_grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_exp(input bit port, input logic [31:0] data, input logic fault);
        exp_t e;
        e.data  = data;
        e.fault = fault;
        e.cyc   = cyc;
        if (port) dq.push_back(e);
        else      fq.push_back(e);
    endtask

    task automatic issue_f(input logic [31:0] addr, input logic [31:0] edata, input logic efault);
        bit ok;
        @(posedge clk); #1;
        i_req_valid = 1'b1;
        i_req_addr  = addr[31:2];
        wait_rdy(1'b0, ok);
        if (ok) push_exp(1'b0, edata, efault);
        @(posedge clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic issue_d(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] edata, input logic efault);
        bit ok;
        @(posedge clk); #1;
        d_req_valid = 1'b1;
        d_req_addr  = addr[31:2];
        d_req_wdata = wdata;
        d_req_wstrb = wstrb;
        wait_rdy(1'b1, ok);
        if (ok) push_exp(1'b1, edata, efault);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50; n++) begin
            if (fq.size() == 0 && dq.size() == 0) break;
            @(negedge clk);
        end
        check("drain_pending", fq.size() + dq.size(), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] fa [3];
        logic [31:0] fe [3];
        logic [31:0] da [3];
        logic [31:0] de [3];
        bit          ok;
        int          fcount, dcount;

        fa = '{32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
        fe = '{32'h1000_0001, 32'h1000_0002, 32'h1000_0003};
        da = '{32'h8000_0010, 32'h8000_0004, 32'h8000_0000};
        de = '{32'hDEAD_BEEF, 32'h0000_3344, 32'hCAFE_F00D};

        rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_wstrb = '0;
        fp_i_valid = 1'b0; fp_d_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {30'd0, i_req_ready, d_req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
        check("rst_rsp_fault", {30'd0, i_rsp_fault, d_rsp_fault}, 32'd0);
        check("rst_i_rsp_data", i_rsp_data, 32'd0);
        check("rst_d_rsp_data", d_rsp_data, 32'd0);
        check("rst_mem_address", {2'b00, mem_address}, 32'd0);
        check("rst_mem_in", mem_in, 32'd0);
        check("rst_mem_we", {28'd0, mem_write_enable}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue_f(32'h0000_0000, 32'h1000_0000, 1'b0);
        issue_d(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        issue_d(32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        issue_d(32'h8000_0004, 32'h1122_3344, 4'h3, 32'h0, 1'b0);
        issue_d(32'h8000_0004, 32'h0, 4'h0, 32'h0000_3344, 1'b0);
        issue_d(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        issue_f(32'h8000_0000, 32'hCAFE_F00D, 1'b0);
        issue_d(32'hFFFF_0000, 32'h0, 4'h0, 32'h0, 1'b1);
        issue_d(32'hFFFF_0004, 32'h0000_00A5, 4'hF, 32'h0, 1'b0);
        drain();
        we_cnt = 0;
        issue_d(32'h0000_0040, 32'h0000_1234, 4'h3, 32'h0, 1'b1);
        drain();
        check("fault_store_we", we_cnt, 32'd0);
        issue_d(32'h4000_0000, 32'h0, 4'h0, 32'h0, 1'b1);
        drain();

        // continuous contention right after reset: fetch first, then strict alternation
        pulse_reset();
        glog.delete();
        log_en = 1'b1;
        @(posedge clk); #1;
        fork
            begin
                bit okf;
                for (int k = 0; k < 3; k++) begin
                    i_req_valid = 1'b1;
                    i_req_addr  = fa[k][31:2];
                    wait_rdy(1'b0, okf);
                    if (okf) push_exp(1'b0, fe[k], 1'b0);
                    @(posedge clk); #1;
                end
                i_req_valid = 1'b0;
            end
            begin
                bit okd;
                for (int k = 0; k < 3; k++) begin
                    d_req_valid = 1'b1;
                    d_req_addr  = da[k][31:2];
                    d_req_wstrb = 4'h0;
                    wait_rdy(1'b1, okd);
                    if (okd) push_exp(1'b1, de[k], 1'b0);
                    @(posedge clk); #1;
                end
                d_req_valid = 1'b0;
            end
        join
        log_en = 1'b0;
        drain();
        for (int k = 0; k < 6; k++)
            check("grant_order", (glog.size() > k) ? glog[k] : 32'd7, k % 2);

        // fixed priority: data wins every contention
        @(posedge clk); #1;
        fp_i_valid = 1'b1;
        fp_d_valid = 1'b1;
        fcount = 0;
        dcount = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (fp_i_ready) fcount++;
            if (fp_d_ready) dcount++;
        end
        fp_i_valid = 1'b0;
        fp_d_valid = 1'b0;
        check("fp_d_grants", dcount, 32'd6);
        check("fp_f_grants", fcount, 32'd0);

        // reset during the ACCESS cycle of a store
        @(posedge clk); #1;
        d_req_valid = 1'b1;
        d_req_addr  = 30'h2000_0008;
        d_req_wdata = 32'h55AA_55AA;
        d_req_wstrb = 4'hF;
        wait_rdy(1'b1, ok);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        check("we_in_access", {28'd0, mem_write_enable}, 32'hF);
        #1 rst_n = 1'b0;
        #1 check("we_after_rst", {28'd0, mem_write_enable}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("no_rsp_in_rst", {31'd0, d_rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue_d(32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        issue_f(32'h0000_0008, 32'h1000_0002, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
